// File: rtl/output_writeback_buffer.sv
// output_writeback_buffer: FIFO-buffered activation row write-back into BRAM A; `define WB_ZERO_INVALID_EN writes all lanes with masked lanes zeroed.
module output_writeback_buffer #(
    parameter int DWIDTH       = 8,
    parameter int MAT_MUL_SIZE = 4,
    parameter int AWIDTH       = 10,
    parameter int MASK_WIDTH   = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start_wb,
    input  logic [AWIDTH-1:0]              address_mat_c,
    input  logic [7:0]                     num_rows,
    input  logic [MASK_WIDTH-1:0]          validity_mask,
    input  logic                           in_data_available,
    input  logic [MAT_MUL_SIZE*DWIDTH-1:0] inp_data,
    input  logic                           bram_read_busy,
    output logic [AWIDTH-1:0]              bram_addr_wr,
    output logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_wdata,
    output logic [MASK_WIDTH-1:0]          bram_we,
    output logic                           bram_wr_req,
    output logic                           fifo_full,
    output logic                           overflow,
    output logic                           done_wb
);
    localparam int RW = MAT_MUL_SIZE * DWIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
    state_t state, state_next;
    logic [AWIDTH-1:0] next_addr;
    logic [7:0] rows, push_cnt, wr_cnt;
    logic [RW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] count, count_next;
    logic active, full, push, pop, drop, last;
    logic [RW-1:0] head, wdata_next;
    logic [MASK_WIDTH-1:0] we_next;
    // a start_wb edge flushes the job, so nothing moves through the FIFO on it
    assign active = state == ACTIVE && !start_wb;
    assign full = count == CW'(FIFO_DEPTH);
    assign pop = active && count != '0 && !bram_read_busy;
    assign push = active && in_data_available && push_cnt < rows && (!full || pop);
    assign drop = active && in_data_available && !push;
    assign last = pop && wr_cnt == rows - 8'd1;
    assign head = mem[rptr];
    assign count_next = count + CW'(push) - CW'(pop);
    assign done_wb = state == DONE;
`ifdef WB_ZERO_INVALID_EN
    always_comb begin
        wdata_next = head;
        for (int i = 0; i < MAT_MUL_SIZE; i++)
            wdata_next[i*DWIDTH +: DWIDTH] = validity_mask[i] ? head[i*DWIDTH +: DWIDTH] : '0;
    end
    assign we_next = '1;
`else
    assign wdata_next = head;
    assign we_next = validity_mask;
`endif
    always_comb begin
        state_next = state;
        if (start_wb) state_next = num_rows == 8'd0 ? DONE : ACTIVE;
        else if (last) state_next = DONE;
    end
    always_ff @(posedge clk) if (push) mem[wptr] <= inp_data;
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            next_addr    <= '0;
            rows         <= '0;
            push_cnt     <= '0;
            wr_cnt       <= '0;
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            fifo_full    <= 1'b0;
            overflow     <= 1'b0;
            bram_addr_wr <= '0;
            bram_wdata   <= '0;
            bram_we      <= '0;
            bram_wr_req  <= 1'b0;
        end else begin
            state        <= state_next;
            bram_addr_wr <= pop ? next_addr : '0;
            bram_wdata   <= pop ? wdata_next : '0;
            bram_we      <= pop ? we_next : '0;
            bram_wr_req  <= pop;
            if (start_wb) begin
                next_addr <= address_mat_c;
                rows      <= num_rows;
                push_cnt  <= '0;
                wr_cnt    <= '0;
                wptr      <= '0;
                rptr      <= '0;
                count     <= '0;
                fifo_full <= 1'b0;
                overflow  <= 1'b0;
            end else begin
                if (push) begin
                    wptr     <= wptr + PW'(1);
                    push_cnt <= push_cnt + 8'd1;
                end
                if (pop) begin
                    rptr      <= rptr + PW'(1);
                    wr_cnt    <= wr_cnt + 8'd1;
                    next_addr <= next_addr + AWIDTH'(MAT_MUL_SIZE);
                end
                count     <= count_next;
                fifo_full <= count_next == CW'(FIFO_DEPTH);
                if (drop) overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_output_writeback_buffer.sv
// tb_output_writeback_buffer: directed checks of output_writeback_buffer; expectations follow WB_ZERO_INVALID_EN when defined.
module tb_output_writeback_buffer;
    logic        clk = 0, reset = 1, start_wb = 0, in_data_available = 0, bram_read_busy = 0;
    logic [9:0]  address_mat_c = '0;
    logic [7:0]  num_rows = '0;
    logic [3:0]  validity_mask = '0;
    logic [31:0] inp_data = '0;
    logic [9:0]  bram_addr_wr;
    logic [31:0] bram_wdata;
    logic [3:0]  bram_we;
    logic        bram_wr_req, fifo_full, overflow, done_wb;
    int total = 0, bad = 0;

    output_writeback_buffer dut (
        .clk(clk), .reset(reset), .start_wb(start_wb), .address_mat_c(address_mat_c),
        .num_rows(num_rows), .validity_mask(validity_mask), .in_data_available(in_data_available),
        .inp_data(inp_data), .bram_read_busy(bram_read_busy), .bram_addr_wr(bram_addr_wr),
        .bram_wdata(bram_wdata), .bram_we(bram_we), .bram_wr_req(bram_wr_req),
        .fifo_full(fifo_full), .overflow(overflow), .done_wb(done_wb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [9:0] base, input logic [7:0] n, input logic [3:0] m);
        start_wb = 1; address_mat_c = base; num_rows = n; validity_mask = m;
        step();
        start_wb = 0;
    endtask

    task automatic push_step(input logic [31:0] d);
        in_data_available = 1; inp_data = d;
        step();
        in_data_available = 0; inp_data = '0;
    endtask

    task automatic wr(input string tag, input logic [9:0] a, input logic [31:0] d, input logic [3:0] we);
        chk({tag, "_req"}, bram_wr_req, 1);
        chk({tag, "_we"}, bram_we, we);
        chk({tag, "_addr"}, bram_addr_wr, a);
        chk({tag, "_data"}, bram_wdata, d);
    endtask

    task automatic idle(input string tag);
        chk({tag, "_req"}, bram_wr_req, 0);
        chk({tag, "_we"}, bram_we, 0);
        chk({tag, "_data"}, bram_wdata, 0);
    endtask

    initial begin
        step(); step();
        idle("rst");
        chk("rst_addr", bram_addr_wr, 0);
        chk("rst_flags", {fifo_full, overflow, done_wb}, 0);
        reset = 0;
        step();
        // back-to-back rows, one write per cycle
        start(10'h040, 8'd4, 4'hF);
        for (int k = 0; k < 4; k++) begin
            push_step(32'hA0B0C0D0 + k);
            if (k == 0) idle("t1_lat");
            else wr($sformatf("t1_w%0d", k - 1), 10'h040 + 10'(4 * (k - 1)), 32'hA0B0C0D0 + k - 1, 4'hF);
            if (k < 3) chk("t1_notdone", done_wb, 0);
        end
        step();
        wr("t1_w3", 10'h04C, 32'hA0B0C0D3, 4'hF);
        chk("t1_done", done_wb, 1);
        chk("t1_ovf", overflow, 0);
        step();
        idle("t1_after");
        chk("t1_done_hold", done_wb, 1);
        // port busy: FIFO fills, fifth row dropped, then push+pop while full
        start(10'h100, 8'd6, 4'hF);
        bram_read_busy = 1;
        for (int k = 0; k < 5; k++) begin
            push_step(32'hE0000000 + k);
            if (k == 3) chk("t2_full", fifo_full, 1);
            if (k == 3) chk("t2_noovf", overflow, 0);
        end
        chk("t2_ovf", overflow, 1);
        idle("t2_busy");
        step();
        idle("t2_busy6");
        bram_read_busy = 0;
        push_step(32'hE0000005);
        wr("t3_w0", 10'h100, 32'hE0000000, 4'hF);
        chk("t3_full_kept", fifo_full, 1);
        step();
        wr("t2_w1", 10'h104, 32'hE0000001, 4'hF);
        chk("t2_notfull", fifo_full, 0);
        step();
        wr("t2_w2", 10'h108, 32'hE0000002, 4'hF);
        step();
        wr("t2_w3", 10'h10C, 32'hE0000003, 4'hF);
        step();
        wr("t3_w5", 10'h110, 32'hE0000005, 4'hF);
        chk("t2_notdone", done_wb, 0);
        chk("t2_ovf_sticky", overflow, 1);
        // restart from ACTIVE; address wraps; extra row beyond num_rows dropped
        start(10'h3FC, 8'd2, 4'hF);
        chk("t4_ovf_clr", overflow, 0);
        chk("t4_active", done_wb, 0);
        push_step(32'h11111111);
        push_step(32'h22222222);
        wr("t4_w0", 10'h3FC, 32'h11111111, 4'hF);
        push_step(32'h33333333);
        wr("t4_w1", 10'h000, 32'h22222222, 4'hF);
        chk("t4_done", done_wb, 1);
        chk("t4_extra_ovf", overflow, 1);
        // lane mask
        start(10'h020, 8'd1, 4'b0101);
        chk("t5_ovf_clr", overflow, 0);
        push_step(32'hAABBCCDD);
        step();
`ifdef WB_ZERO_INVALID_EN
        wr("t5_w", 10'h020, 32'h00BB00DD, 4'hF);
`else
        wr("t5_w", 10'h020, 32'hAABBCCDD, 4'b0101);
`endif
        chk("t5_done", done_wb, 1);
        push_step(32'h55555555);
        chk("t5_done_ignore", overflow, 0);
        idle("t5_done_idle");
        // empty job
        start(10'h000, 8'd0, 4'hF);
        chk("t0_done", done_wb, 1);
        // reset mid-job
        start(10'h080, 8'd4, 4'hF);
        push_step(32'hC0000000);
        push_step(32'hC0000001);
        wr("t6_w0", 10'h080, 32'hC0000000, 4'hF);
        push_step(32'hC0000002);
        wr("t6_w1", 10'h084, 32'hC0000001, 4'hF);
        reset = 1;
        push_step(32'hC0000003);
        idle("t6_rst");
        chk("t6_rst_addr", bram_addr_wr, 0);
        chk("t6_rst_flags", {fifo_full, overflow, done_wb}, 0);
        reset = 0;
        step();
        idle("t6_idle");
        chk("t6_idle_done", done_wb, 0);
        start(10'h200, 8'd1, 4'hF);
        push_step(32'hD0D0D0D0);
        step();
        wr("t6_new", 10'h200, 32'hD0D0D0D0, 4'hF);
        chk("t6_new_done", done_wb, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
